// File: rtl/mux8_serializer.sv
// Parallel-to-serial front end for mux8x1: accepts 8-bit words over valid/ready
// and steps the mux select through all bit positions, BIT_CYCLES clocks each.
module mux8_serializer #(
   parameter int unsigned BIT_CYCLES = 1,
   parameter bit          MSB_FIRST  = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [7:0] x,
   output logic [2:0] sel,
   output logic       bit_valid,
   output logic       bit_last,
   output logic       done
);

   localparam int unsigned CW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BIT_CYCLES - 1);
   localparam logic [2:0] SEL_FIRST  = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [2:0] SEL_LAST   = MSB_FIRST ? 3'd0 : 3'd7;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [7:0]      r_x;
   logic [7:0]      w_x_nxt;
   logic [2:0]      r_sel;
   logic [2:0]      w_sel_nxt;
   logic            r_bit_valid;
   logic            r_bit_last;
   logic            r_done;
   logic            w_bit_valid_nxt;
   logic            w_bit_last_nxt;
   logic            w_done_nxt;
   logic            w_final;
   logic            w_accept;
   logic [2:0]      w_sel_step;

   // Last clock of the last bit: the only cycle a new word may load mid-stream
   assign w_final    = (r_state == SHIFT) && (r_sel == SEL_LAST) && (r_cnt == CNT_MAX);
   assign in_ready   = rst_n & ((r_state == IDLE) | w_final);
   assign w_accept   = in_valid & in_ready;
   assign w_sel_step = MSB_FIRST ? 3'(r_sel - 3'd1) : 3'(r_sel + 3'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_x_nxt         = r_x;
      w_sel_nxt       = r_sel;
      w_bit_valid_nxt = 1'b0;
      w_bit_last_nxt  = 1'b0;
      w_done_nxt      = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = SHIFT;
               w_x_nxt     = in_data;
               w_sel_nxt   = SEL_FIRST;
               w_cnt_nxt   = '0;
            end
         end
         SHIFT: begin
            if (w_final) begin
               if (w_accept) begin
                  w_x_nxt   = in_data;
                  w_sel_nxt = SEL_FIRST;
                  w_cnt_nxt = '0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (r_cnt == CNT_MAX) begin
               w_cnt_nxt = '0;
               w_sel_nxt = w_sel_step;
            end else begin
               w_cnt_nxt = CW'(r_cnt + 1'b1);
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // Flags describe the cycle being entered, so they are registered with it
      w_bit_valid_nxt = (w_state_nxt == SHIFT);
      w_bit_last_nxt  = w_bit_valid_nxt && (w_sel_nxt == SEL_LAST);
      w_done_nxt      = w_bit_last_nxt && (w_cnt_nxt == CNT_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_x         <= '0;
         r_sel       <= '0;
         r_bit_valid <= 1'b0;
         r_bit_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_x         <= w_x_nxt;
         r_sel       <= w_sel_nxt;
         r_bit_valid <= w_bit_valid_nxt;
         r_bit_last  <= w_bit_last_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign x         = r_x;
   assign sel       = r_sel;
   assign bit_valid = r_bit_valid;
   assign bit_last  = r_bit_last;
   assign done      = r_done;

endmodule

// File: tb/tb_mux8_serializer.sv
// Directed bench for mux8_serializer: three instances cover LSB/BIT_CYCLES=1,
// MSB/BIT_CYCLES=3 and LSB/BIT_CYCLES=2; y is modelled as mux8x1 (x[sel]).
module tb_mux8_serializer;

   logic       clk = 1'b0;
   logic       vld;
   logic [7:0] dat;
   logic       rst0, rst1, rst2;

   logic       rdy0, bv0, bl0, dn0, y0;
   logic [7:0] x0;
   logic [2:0] sel0;
   logic       rdy1, bv1, bl1, dn1, y1;
   logic [7:0] x1;
   logic [2:0] sel1;
   logic       rdy2, bv2, bl2, dn2, y2;
   logic [7:0] x2;
   logic [2:0] sel2;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_b2b = 16'b0011110010100101;
   logic [7:0]  exp_c1  = 8'b10000011;
   logic [7:0]  exp_81  = 8'b10000001;

   always #5 clk = ~clk;

   mux8_serializer #(.BIT_CYCLES(1), .MSB_FIRST(1'b0)) u0 (
      .clk(clk), .rst_n(rst0), .in_valid(vld), .in_data(dat), .in_ready(rdy0),
      .x(x0), .sel(sel0), .bit_valid(bv0), .bit_last(bl0), .done(dn0));
   mux8_serializer #(.BIT_CYCLES(3), .MSB_FIRST(1'b1)) u1 (
      .clk(clk), .rst_n(rst1), .in_valid(vld), .in_data(dat), .in_ready(rdy1),
      .x(x1), .sel(sel1), .bit_valid(bv1), .bit_last(bl1), .done(dn1));
   mux8_serializer #(.BIT_CYCLES(2), .MSB_FIRST(1'b0)) u2 (
      .clk(clk), .rst_n(rst2), .in_valid(vld), .in_data(dat), .in_ready(rdy2),
      .x(x2), .sel(sel2), .bit_valid(bv2), .bit_last(bl2), .done(dn2));

   assign y0 = x0[sel0];
   assign y1 = x1[sel1];
   assign y2 = x2[sel2];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      vld  = 1'b1;
      dat  = 8'hFF;
      rst0 = 1'b0;
      rst1 = 1'b0;
      rst2 = 1'b0;

      // reset held with a word offered
      repeat (2) @(negedge clk);
      chk("rst_ready",  8'(rdy0), 8'd0);
      chk("rst_x",      x0,       8'h00);
      chk("rst_sel",    8'(sel0), 8'd0);
      chk("rst_bv",     8'(bv0),  8'd0);
      chk("rst_bl",     8'(bl0),  8'd0);
      chk("rst_done",   8'(dn0),  8'd0);
      chk("rst_sel_msb", 8'(sel1), 8'd0);
      rst0 = 1'b1;
      #1 chk("rel_ready", 8'(rdy0), 8'd1);
      @(negedge clk);
      vld = 1'b0;
      chk("first_x",   x0,       8'hFF);
      chk("first_sel", 8'(sel0), 8'd0);
      chk("first_bv",  8'(bv0),  8'd1);
      repeat (7) @(negedge clk);
      chk("first_done", 8'(dn0),  8'd1);
      chk("first_last", 8'(bl0),  8'd1);
      chk("first_rdy",  8'(rdy0), 8'd1);
      @(negedge clk);
      chk("first_idle", 8'(bv0), 8'd0);

      // LSB-first single word 8'h80
      vld = 1'b1;
      dat = 8'h80;
      @(negedge clk);
      vld = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("w80_sel",  8'(sel0), 8'(i));
         chk("w80_y",    8'(y0),   8'(i == 7));
         chk("w80_last", 8'(bl0),  8'(i == 7));
         chk("w80_done", 8'(dn0),  8'(i == 7));
         chk("w80_bv",   8'(bv0),  8'd1);
         @(negedge clk);
      end
      chk("w80_idle_bv",  8'(bv0),  8'd0);
      chk("w80_idle_rdy", 8'(rdy0), 8'd1);
      chk("w80_idle_sel", 8'(sel0), 8'd7);
      chk("w80_idle_x",   x0,       8'h80);

      // back-to-back A5 then 3C
      vld = 1'b1;
      dat = 8'hA5;
      @(negedge clk);
      dat = 8'h3C;
      for (int i = 0; i < 16; i++) begin
         chk("b2b_bv",   8'(bv0), 8'd1);
         chk("b2b_y",    8'(y0),  8'(exp_b2b[i]));
         chk("b2b_done", 8'(dn0), 8'(i == 7 || i == 15));
         if (i == 3) chk("b2b_rdy_mid", 8'(rdy0), 8'd0);
         if (i == 7) chk("b2b_rdy_fin", 8'(rdy0), 8'd1);
         if (i == 8) vld = 1'b0;
         @(negedge clk);
      end
      chk("b2b_idle", 8'(bv0), 8'd0);

      // MSB-first, 3 clocks per bit, word C1
      rst1 = 1'b1;
      vld  = 1'b1;
      dat  = 8'hC1;
      @(negedge clk);
      vld = 1'b0;
      for (int c = 0; c < 24; c++) begin
         chk("msb_sel",  8'(sel1), 8'(7 - c / 3));
         chk("msb_y",    8'(y1),   8'(exp_c1[c / 3]));
         chk("msb_last", 8'(bl1),  8'(c >= 21));
         chk("msb_done", 8'(dn1),  8'(c == 23));
         chk("msb_bv",   8'(bv1),  8'd1);
         @(negedge clk);
      end
      chk("msb_idle", 8'(bv1), 8'd0);

      // stimulus while shifting is ignored
      vld = 1'b1;
      dat = 8'h0F;
      @(negedge clk);
      dat = 8'hF0;
      for (int i = 0; i < 8; i++) begin
         chk("ign_rdy", 8'(rdy0), 8'(i == 7));
         chk("ign_x",   x0,       8'h0F);
         chk("ign_y",   8'(y0),   8'(i < 4));
         vld = (i < 7) && (i % 2 == 0);
         @(negedge clk);
      end
      chk("ign_idle_bv", 8'(bv0), 8'd0);
      chk("ign_idle_x",  x0,      8'h0F);

      // async reset mid-word, 2 clocks per bit
      rst2 = 1'b1;
      vld  = 1'b1;
      dat  = 8'h55;
      @(negedge clk);
      vld = 1'b0;
      repeat (8) @(negedge clk);
      chk("ar_sel_pre", 8'(sel2), 8'd4);
      #2 rst2 = 1'b0;
      #1;
      chk("ar_x",    x2,       8'h00);
      chk("ar_sel",  8'(sel2), 8'd0);
      chk("ar_bv",   8'(bv2),  8'd0);
      chk("ar_bl",   8'(bl2),  8'd0);
      chk("ar_done", 8'(dn2),  8'd0);
      chk("ar_rdy",  8'(rdy2), 8'd0);
      repeat (3) @(negedge clk);
      chk("ar_held_done", 8'(dn2), 8'd0);
      rst2 = 1'b1;
      vld  = 1'b1;
      dat  = 8'h81;
      @(negedge clk);
      vld = 1'b0;
      for (int c = 0; c < 16; c++) begin
         chk("ar81_sel",  8'(sel2), 8'(c / 2));
         chk("ar81_y",    8'(y2),   8'(exp_81[c / 2]));
         chk("ar81_done", 8'(dn2),  8'(c == 15));
         chk("ar81_bv",   8'(bv2),  8'd1);
         @(negedge clk);
      end
      chk("ar81_idle", 8'(bv2), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
